// File: rtl/alu_multicycle.sv
// Multicycle ALU: one operation per handshake with a registered result. Most ops take one cycle;
// MUL (shift-add) and DIV (restoring) iterate WIDTH cycles. Define ALU_DIV_EN to build the divider.
module alu_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         opcode,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [WIDTH-1:0]   imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               err
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_err, op_mul, op_div;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   step_hi, step_lo;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]     div_shift, div_trial;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign err       = err_q;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    op_mul  = 1'b0;
    op_div  = 1'b0;
    case (opcode)
      6'h00:   alu_res = imm;
      6'h01:   alu_res = src_a;
      6'h04:   alu_res = src_b + src_a;
      6'h05:   alu_res = src_b - src_a;
      6'h06:   alu_res = -src_a;
      6'h07:   op_mul  = 1'b1;
`ifdef ALU_DIV_EN
      6'h08:   op_div  = 1'b1;
`endif
      6'h09:   alu_res = src_b | src_a;
      6'h0A:   alu_res = src_b ^ src_a;
      6'h0B:   alu_res = ~(src_b & src_a);
      6'h0C:   alu_res = ~(src_b | src_a);
      6'h0D:   alu_res = ~(src_b ^ src_a);
      6'h0E:   alu_res = ~src_a;
      6'h0F:   alu_res = src_b << src_a[SHW-1:0];
      6'h10:   alu_res = src_b >> src_a[SHW-1:0];
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    result_d = result_q;
    err_d    = err_q;

    // MUL: {hi,lo} shifts right, adding the multiplicand into hi when the multiplier LSB is set
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    // DIV: hi holds the partial remainder, quotient bits shift into lo from the right
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
    end
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d    = '0;
          is_div_d = 1'b0;
          result_d = {{WIDTH{1'b0}}, alu_res};
          err_d    = alu_err;
          state_d  = DONE;
          if (op_mul) begin
            hi_d    = '0;
            lo_d    = src_a;
            opnd_d  = src_b;
            state_d = BUSY;
          end else if (op_div) begin
            if (src_a == '0) begin
              result_d = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              err_d    = 1'b1;
            end else begin
              hi_d     = '0;
              lo_d     = src_b;
              opnd_d   = src_a;
              is_div_d = 1'b1;
              state_d  = BUSY;
            end
          end
        end
      end
      BUSY: begin
        hi_d = step_hi;
        lo_d = step_lo;
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d  = DONE;
          err_d    = 1'b0;
          result_d = is_div_q ? {{WIDTH{1'b0}}, step_lo} : {step_hi, step_lo};
        end else begin
          cnt_d = cnt_q + SHW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes model results, a negedge monitor checks them.
module tb_alu_multicycle;
  localparam int W = 16;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    opcode;
  logic [W-1:0]  src_a, src_b, imm;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic          err;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    longint      t_issue;
    logic [5:0]  op;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  logic prev_valid = 1'b0;
  logic [5:0] legal_ops [15] = '{6'h00, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10};

  alu_multicycle #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .src_a     (src_a),
    .src_b     (src_b),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Write-back readiness: random, forced low (stall) or forced high
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      1:       out_ready = 1'b0;
      2:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] im);
    exp_t e;
    logic [15:0] t;
    e.res = 32'h0; e.err = 1'b0; e.lat = 1; e.t_issue = 0; e.op = op;
    t = 16'h0;
    case (op)
      6'h00: t = im;
      6'h01: t = a;
      6'h04: t = b + a;
      6'h05: t = b - a;
      6'h06: t = 16'h0 - a;
      6'h09: t = b | a;
      6'h0A: t = b ^ a;
      6'h0B: t = ~(b & a);
      6'h0C: t = ~(b | a);
      6'h0D: t = ~(b ^ a);
      6'h0E: t = ~a;
      6'h0F: t = b << (a % 16);
      6'h10: t = b >> (a % 16);
      6'h07: e.lat = W + 1;
`ifdef ALU_DIV_EN
      6'h08: begin
        if (a == 16'h0) begin
          t = 16'hFFFF;
          e.err = 1'b1;
        end else begin
          t = b / a;
          e.lat = W + 1;
        end
      end
`endif
      default: e.err = 1'b1;
    endcase
    if (op == 6'h07) e.res = {16'h0, b} * {16'h0, a};
    else e.res = {16'h0, t};
    return e;
  endfunction

  // Monitor: every cycle with out_valid, compare against the oldest outstanding expectation
  always @(negedge clock) begin
    if (reset !== 1'b0) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected out_valid", 32'(out_valid), 32'h0);
        end else begin
          if (!prev_valid)
            checkOutput($sformatf("latency op=%h", sb[0].op), 32'(($time - sb[0].t_issue) / 10),
                        32'(sb[0].lat));
          checkOutput($sformatf("result op=%h", sb[0].op), result, sb[0].res);
          checkOutput($sformatf("err op=%h", sb[0].op), 32'(err), 32'(sb[0].err));
          checkOutput("in_ready while out_valid", 32'(in_ready), 32'h0);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid <= (out_valid === 1'b1);
    end
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] im);
    exp_t e;
    int waited;
    waited = 0;
    @(negedge clock);
    while (!in_ready && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("in_ready timeout", 32'(in_ready), 32'h1);
      return;
    end
    in_valid = 1'b1;
    opcode   = op;
    src_a    = a;
    src_b    = b;
    imm      = im;
    e = model(op, a, b, im);
    e.t_issue = $time;
    sb.push_back(e);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && in_ready) break;
      @(negedge clock);
    end
    checkOutput("drain outstanding", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    opcode   = 6'h0;
    src_a    = '0;
    src_b    = '0;
    imm      = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset in_ready", 32'(in_ready), 32'h1);
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset result", result, 32'h0);
    checkOutput("reset err", 32'(err), 32'h0);

    applyStimulus(6'h04, 16'h0001, 16'hFFFF, 16'h0);
    applyStimulus(6'h05, 16'h0005, 16'h0002, 16'h0);
    applyStimulus(6'h07, 16'hFFFF, 16'hFFFF, 16'h0);
    applyStimulus(6'h08, 16'd7, 16'd100, 16'h0);
    applyStimulus(6'h08, 16'h0, 16'h1234, 16'h0);
    applyStimulus(6'h0F, 16'h0013, 16'h0001, 16'h0);
    applyStimulus(6'h3F, 16'h1111, 16'h2222, 16'h3333);
    applyStimulus(6'h00, 16'h1111, 16'h2222, 16'hABCD);
    applyStimulus(6'h06, 16'h0001, 16'h0, 16'h0);
    waitIdle();

    // Stall: result held while write-back is not ready; a new in_valid must be ignored
    ready_mode = 1;
    repeat (2) @(negedge clock);
    applyStimulus(6'h04, 16'h0030, 16'h0012, 16'h0);
    in_valid = 1'b1;
    opcode   = 6'h05;
    src_a    = 16'h7777;
    src_b    = 16'h1;
    repeat (5) @(negedge clock);
    ready_mode = 2;
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    ready_mode = 0;
    waitIdle();

    for (int n = 0; n < 50; n++) begin
      logic [5:0]  op;
      logic [15:0] a;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : legal_ops[$urandom_range(0, 14)];
      a  = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      applyStimulus(op, a, 16'($urandom), 16'($urandom));
    end
    waitIdle();

    // Reset in the middle of a multiply discards it entirely
    applyStimulus(6'h04, 16'h0001, 16'h0002, 16'h0);
    waitIdle();
    @(negedge clock);
    in_valid = 1'b1;
    opcode   = 6'h07;
    src_a    = 16'd3;
    src_b    = 16'd5;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("post-reset in_ready", 32'(in_ready), 32'h1);
    checkOutput("post-reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("post-reset result", result, 32'h0);
    checkOutput("post-reset err", 32'(err), 32'h0);
    repeat (20) @(negedge clock);
    applyStimulus(6'h07, 16'd3, 16'd5, 16'h0);
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
